// File: rtl/conv_pim_pkg.sv
// Shared definitions for the sliced processing-in-memory MAC.
//   pim_state_e : control FSM encoding (IDLE / COMPUTE / DONE)
//   clogb2      : number of bits needed to hold the value n (minimum 1).
//                 Address ports are sized with clogb2(N_ADDR) so that
//                 out-of-range rows (in_addr >= N_ADDR) can be presented
//                 and flagged. Array index widths use clogb2(N-1).
package conv_pim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } pim_state_e;

    function automatic int clogb2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                bits = bits + 1;
                v    = v >> 1;
            end
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/pim_slice_array.sv
// Weight storage plus ADC model of the PIM array.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (clears weights)
//   wr_en           : write strobe, already qualified by the controller
//   wr_row, wr_tap  : write location (in range when wr_en is high)
//   wr_data         : unsigned weight
//   rd_row, rd_ok   : selected kernel row; rd_ok low forces a zero result
//   slice_data      : one SLICE_W-bit slice per tap, tap 0 in the LSBs
//   adc_data        : registered dot product, saturated to 2^ADC_P-1
//   adc_sat         : registered flag, high when the dot product clipped
module pim_slice_array
    import conv_pim_pkg::*;
#(
    parameter int SLICE_W = 3,
    parameter int K       = 25,
    parameter int W_W     = 3,
    parameter int N_ADDR  = 4,
    parameter int ADC_P   = 6,
    localparam int RIDX_W = clogb2(N_ADDR - 1),
    localparam int TIDX_W = clogb2(K - 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [RIDX_W-1:0]    wr_row,
    input  logic [TIDX_W-1:0]    wr_tap,
    input  logic [W_W-1:0]       wr_data,
    input  logic [RIDX_W-1:0]    rd_row,
    input  logic                 rd_ok,
    input  logic [K*SLICE_W-1:0] slice_data,
    output logic [ADC_P-1:0]     adc_data,
    output logic                 adc_sat
);

    // Full-precision dot product width: product bits plus carry growth over K taps.
    localparam int DOT_W = SLICE_W + W_W + clogb2(K);
    localparam logic [DOT_W-1:0] ADC_MAX = DOT_W'((1 << ADC_P) - 1);

    logic [W_W-1:0]   weight_r [N_ADDR][K];
    logic [DOT_W-1:0] dot_s;
    logic             clip_s;
    logic [ADC_P-1:0] adc_data_r;
    logic             adc_sat_r;

    // Unclipped dot product of the presented slice with the selected row.
    always_comb begin
        dot_s = {DOT_W{1'b0}};
        if (rd_ok) begin
            for (int k = 0; k < K; k++) begin
                dot_s = dot_s + DOT_W'(slice_data[k*SLICE_W +: SLICE_W])
                              * DOT_W'(weight_r[rd_row][k]);
            end
        end else begin
            dot_s = {DOT_W{1'b0}};
        end
        clip_s = (dot_s > ADC_MAX);
    end

    // Weight storage and the registered, saturating ADC sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N_ADDR; r++) begin
                for (int k = 0; k < K; k++) begin
                    weight_r[r][k] <= {W_W{1'b0}};
                end
            end
            adc_data_r <= {ADC_P{1'b0}};
            adc_sat_r  <= 1'b0;
        end else begin
            if (wr_en) begin
                weight_r[wr_row][wr_tap] <= wr_data;
            end
            adc_data_r <= clip_s ? ADC_MAX[ADC_P-1:0] : dot_s[ADC_P-1:0];
            adc_sat_r  <= clip_s;
        end
    end

    assign adc_data = adc_data_r;
    assign adc_sat  = adc_sat_r;

endmodule

// File: rtl/conv_pim_sliced_mac.sv
// Bit-sliced convolution MAC on a PIM array. A request carries K activations
// of DATA_W bits; they are fed to the array SLICE_W bits at a time (LSB slice
// first) and the ADC results are shifted and accumulated into out_data.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_data, in_addr          : activations (tap 0 in LSBs), kernel row select
//   in_valid / in_ready       : request handshake (ready only in IDLE)
//   w_we, w_addr, w_tap, w_data : weight write port, honoured only in IDLE
//   w_drop                    : one-cycle pulse for each ignored write
//   out_data, out_sat, out_err: result, sticky ADC-saturation flag, bad-row flag
//   out_valid / out_ready     : result handshake
module conv_pim_sliced_mac
    import conv_pim_pkg::*;
#(
    parameter int DATA_W  = 6,
    parameter int SLICE_W = 3,
    parameter int K       = 25,
    parameter int W_W     = 3,
    parameter int N_ADDR  = 4,
    parameter int ADC_P   = 6,
    localparam int NS     = DATA_W / SLICE_W,
    localparam int AW     = clogb2(N_ADDR),
    localparam int TAP_W  = clogb2(K),
    localparam int OUT_W  = ADC_P + DATA_W
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [K*DATA_W-1:0] in_data,
    input  logic [AW-1:0]       in_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic [TAP_W-1:0]    w_tap,
    input  logic [W_W-1:0]      w_data,
    output logic                w_drop,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sat,
    output logic                out_err
);

    localparam int RIDX_W = clogb2(N_ADDR - 1);
    localparam int TIDX_W = clogb2(K - 1);
    // Counter runs 0..NS+1: NS issue cycles, one drain cycle for the ADC
    // register, one settle cycle so DONE lands NS+2 edges after acceptance.
    localparam int CNT_W  = clogb2(NS + 1);

    pim_state_e          state_r;
    pim_state_e          state_next_s;
    logic                accept_s;
    logic [K*DATA_W-1:0] data_r;
    logic [AW-1:0]       addr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [OUT_W-1:0]    acc_r;
    logic [OUT_W-1:0]    acc_add_s;
    logic                acc_en_s;
    logic                out_sat_r;
    logic                out_err_r;
    logic                w_drop_r;
    logic                wr_ok_s;
    logic                row_ok_s;
    logic [K*SLICE_W-1:0] slice_s;
    logic [ADC_P-1:0]    adc_data_s;
    logic                adc_sat_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and request acceptance.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_COMPUTE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (cnt_r == CNT_W'(NS + 1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Write qualification, row range check and the slice presented this cycle.
    always_comb begin
        wr_ok_s  = w_we && (state_r == ST_IDLE)
                   && (int'(w_addr) < N_ADDR) && (int'(w_tap) < K);
        row_ok_s = (int'(addr_r) < N_ADDR);
        slice_s  = {(K*SLICE_W){1'b0}};
        for (int k = 0; k < K; k++) begin
            if (int'(cnt_r) < NS) begin
                slice_s[k*SLICE_W +: SLICE_W] =
                    data_r[k*DATA_W + int'(cnt_r)*SLICE_W +: SLICE_W];
            end else begin
                slice_s[k*SLICE_W +: SLICE_W] = {SLICE_W{1'b0}};
            end
        end
    end

    // The ADC register holds slice cnt-1, so it is weighted by its bit position.
    always_comb begin
        acc_en_s  = (state_r == ST_COMPUTE) && (cnt_r != {CNT_W{1'b0}})
                    && (int'(cnt_r) <= NS);
        if (acc_en_s) begin
            acc_add_s = OUT_W'(adc_data_s) << (SLICE_W * (int'(cnt_r) - 1));
        end else begin
            acc_add_s = {OUT_W{1'b0}};
        end
    end

    // Request capture, slice counter, accumulator, flags and write-drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r    <= {(K*DATA_W){1'b0}};
            addr_r    <= {AW{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {OUT_W{1'b0}};
            out_sat_r <= 1'b0;
            out_err_r <= 1'b0;
            w_drop_r  <= 1'b0;
        end else begin
            w_drop_r <= w_we && !wr_ok_s;
            if (accept_s) begin
                data_r    <= in_data;
                addr_r    <= in_addr;
                cnt_r     <= {CNT_W{1'b0}};
                acc_r     <= {OUT_W{1'b0}};
                out_sat_r <= 1'b0;
                out_err_r <= !(int'(in_addr) < N_ADDR);
            end else if (state_r == ST_COMPUTE) begin
                cnt_r <= cnt_r + CNT_W'(1);
                acc_r <= acc_r + acc_add_s;
                if (acc_en_s && adc_sat_s) begin
                    out_sat_r <= 1'b1;
                end
            end
        end
    end

    pim_slice_array #(
        .SLICE_W (SLICE_W),
        .K       (K),
        .W_W     (W_W),
        .N_ADDR  (N_ADDR),
        .ADC_P   (ADC_P)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_ok_s),
        .wr_row     (w_addr[RIDX_W-1:0]),
        .wr_tap     (w_tap[TIDX_W-1:0]),
        .wr_data    (w_data),
        .rd_row     (addr_r[RIDX_W-1:0]),
        .rd_ok      (row_ok_s),
        .slice_data (slice_s),
        .adc_data   (adc_data_s),
        .adc_sat    (adc_sat_s)
    );

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign out_data  = acc_r;
    assign out_sat   = out_sat_r;
    assign out_err   = out_err_r;
    assign w_drop    = w_drop_r;

endmodule

// File: tb/tb_conv_pim_sliced_mac.sv
// Directed self-checking bench for conv_pim_sliced_mac at default parameters.
module tb_conv_pim_sliced_mac;

    localparam int DATA_W = 6;
    localparam int K      = 25;
    localparam int W_W    = 3;
    localparam int AW     = 3;
    localparam int TAP_W  = 5;
    localparam int OUT_W  = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [K*DATA_W-1:0] in_data;
    logic [AW-1:0]       in_addr;
    logic                in_valid;
    logic                in_ready;
    logic                w_we;
    logic [AW-1:0]       w_addr;
    logic [TAP_W-1:0]    w_tap;
    logic [W_W-1:0]      w_data;
    logic                w_drop;
    logic [OUT_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_sat;
    logic                out_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_pim_sliced_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_tap     (w_tap),
        .w_data    (w_data),
        .w_drop    (w_drop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    function automatic logic [K*DATA_W-1:0] fill(input int v);
        logic [K*DATA_W-1:0] r;
        r = '0;
        for (int t = 0; t < K; t++) r[t*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    task automatic load_row(input int addr, input int w);
        for (int t = 0; t < K; t++) begin
            w_we = 1'b1; w_addr = AW'(addr); w_tap = TAP_W'(t); w_data = W_W'(w);
            @(posedge clk); #1;
        end
        w_we = 1'b0;
        checks++;
        if (w_drop !== 1'b0) begin
            errors++; $display("FAIL load_row_drop: w_drop=%b expected 0", w_drop);
        end
    endtask

    task automatic start_req(input int v, input int addr);
        in_data = fill(v); in_addr = AW'(addr); in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL start_ready: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid (counting edges since acceptance), checks, then completes the handshake.
    task automatic wait_result(input int start_n, input string name, input int exp_data,
                               input logic exp_sat, input logic exp_err);
        int  n;
        bit  seen;
        n = start_n; seen = 1'b0;
        while (n < 12 && !seen) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        checks++;
        if (!seen || n != 4) begin
            errors++; $display("FAIL %s_latency: seen=%0d edges=%0d expected 4", name, seen, n);
        end
        checks++;
        if (out_data !== OUT_W'(exp_data)) begin
            errors++; $display("FAIL %s_data: got %0d expected %0d", name, out_data, exp_data);
        end
        checks++;
        if (out_sat !== exp_sat || out_err !== exp_err) begin
            errors++; $display("FAIL %s_flags: sat=%b err=%b expected sat=%b err=%b",
                               name, out_sat, out_err, exp_sat, exp_err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_handshake: out_valid=%b in_ready=%b expected 0/1",
                               name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_data: got %0d expected 0", out_data);
        end
        checks++;
        if (out_sat !== 1'b0 || out_err !== 1'b0 || w_drop !== 1'b0) begin
            errors++; $display("FAIL reset_flags: sat=%b err=%b drop=%b expected 0", out_sat, out_err, w_drop);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unit_weights();
        load_row(0, 1);
        start_req(1, 0);
        wait_result(0, "ones", 25, 1'b0, 1'b0);
        start_req(8, 0);
        wait_result(0, "eights", 200, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        load_row(1, 7);
        start_req(63, 1);
        wait_result(0, "sat", 567, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  seen;
        start_req(1, 0);
        n = 0; seen = 1'b0;
        while (n < 12 && !seen) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_valid: out_valid never rose within %0d edges", n);
        end
        in_data = fill(2); in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== OUT_W'(25) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: cycle %0d data=%0d valid=%b ready=%b expected 25/1/0",
                                   c, out_data, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_no_accept: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_write_drop();
        start_req(1, 0);
        w_we = 1'b1; w_addr = 3'd0; w_tap = 5'd0; w_data = 3'd0;
        @(posedge clk); #1;
        w_we = 1'b0;
        checks++;
        if (w_drop !== 1'b1) begin
            errors++; $display("FAIL drop_compute: w_drop=%b expected 1", w_drop);
        end
        @(posedge clk); #1;
        checks++;
        if (w_drop !== 1'b0) begin
            errors++; $display("FAIL drop_pulse: w_drop=%b expected 0", w_drop);
        end
        wait_result(2, "drop_run", 25, 1'b0, 1'b0);
        w_we = 1'b1; w_addr = 3'd0; w_tap = 5'd25; w_data = 3'd0;
        @(posedge clk); #1;
        w_we = 1'b0;
        checks++;
        if (w_drop !== 1'b1) begin
            errors++; $display("FAIL drop_tap: w_drop=%b expected 1", w_drop);
        end
        start_req(1, 0);
        wait_result(0, "weights_kept", 25, 1'b0, 1'b0);
    endtask

    task automatic test_bad_addr();
        w_we = 1'b1; w_addr = 3'd5; w_tap = 5'd0; w_data = 3'd3;
        @(posedge clk); #1;
        w_we = 1'b0;
        checks++;
        if (w_drop !== 1'b1) begin
            errors++; $display("FAIL drop_addr: w_drop=%b expected 1", w_drop);
        end
        start_req(63, 5);
        wait_result(0, "bad_addr", 0, 1'b0, 1'b1);
    endtask

    task automatic test_write_with_request();
        w_we = 1'b1; w_addr = 3'd2; w_tap = 5'd0; w_data = 3'd7;
        start_req(1, 2);
        w_we = 1'b0;
        wait_result(0, "wr_same_cycle", 7, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        start_req(1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_no_valid: out_valid pulsed after reset, expected none");
        end
        start_req(1, 0);
        wait_result(0, "after_rst", 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_addr = '0; in_valid = 1'b0; out_ready = 1'b0;
        w_we = 1'b0; w_addr = '0; w_tap = '0; w_data = '0;
        test_reset();
        test_unit_weights();
        test_saturation();
        test_back_to_back();
        test_write_drop();
        test_bad_addr();
        test_write_with_request();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
